issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue controller between the decoder and the execution units (alu, shifter, branch, lsu, multiplier, divider).
- Holds one decoded instruction and tracks pending destination registers in a 32-entry scoreboard.
- Issues the instruction to its one-hot target unit only when there is no RAW/WAW hazard and the unit is ready.
- Serialising instructions (CSR, ecall/ebreak, fence, illegal) are executed alone, behind a drain/wait state machine.

Parameters:
- NBR_UNIT, 6: width of one-hot unit select; bit order {div, mul, lsu, branch, shift, alu}.
- NBR_OPERATION, 6: width of the operation field, passed through unchanged.
- NBR_WB, 2: number of writeback ports that clear scoreboard entries.
- XLEN, 32: width of immediate and pc fields.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of buffered instruction and scoreboard
- dec_valid_i  in  1  decoded instruction valid
- dec_ready_o  out  1  buffer can accept this cycle
- dec_rs1_v_i / dec_rs2_v_i / dec_rd_v_i  in  1 each  register-use flags
- dec_rs1_i / dec_rs2_i / dec_rd_i  in  5 each  register indices
- dec_unit_i  in  NBR_UNIT  one-hot target unit
- dec_op_i  in  NBR_OPERATION  operation code
- dec_imm_i  in  XLEN  immediate
- dec_pc_i  in  XLEN  pc
- dec_serial_i  in  1  serialising instruction
- dec_illegal_i  in  1  illegal instruction
- iss_valid_o  out  1  issue request
- iss_unit_o  out  NBR_UNIT  buffered unit select
- iss_op_o, iss_imm_o, iss_pc_o, iss_rs1_o, iss_rs2_o, iss_rd_o, iss_rd_v_o, iss_illegal_o  out  buffered fields
- unit_ready_i  in  NBR_UNIT  per-unit accept
- wb_valid_i  in  NBR_WB  writeback valid per port
- wb_rd_i  in  5*NBR_WB  writeback register per port
- serial_done_i  in  1  serialised instruction retired
- stall_cnt_o  out  32  cycles with a buffered instruction not issued

Behaviour:
- Reset (async, reset_n=0):
  - Buffer empty, pending[31:0]=0, state=RUN, stall_cnt_o=0.
  - iss_valid_o=0 and all iss_* fields 0.
  - dec_ready_o=1 after reset release.
- Buffer (one entry):
  - accept = dec_valid_i & dec_ready_o.
  - dec_ready_o = ~buf_v | fire, and is 0 in state SERIAL and during flush_i.
  - Accept and fire in the same cycle give back-to-back throughput (one instruction per cycle).
- Scoreboard:
  - pending[0] is hard-wired 0.
  - clr[r] = OR over ports p of (wb_valid_i[p] & wb_rd_i[p]==r).
  - eff[r] = pending[r] & ~clr[r]; this is a same-cycle writeback bypass.
- Hazard: hz = (rs1_v & eff[rs1]) | (rs2_v & eff[rs2]) | (rd_v & eff[rd]), where rs1/rs2/rd/*_v are the buffered fields. WAW stalls, so one bit per register suffices.
- Issue:
  - iss_valid_o = buf_v & ~hz & state_allows.
  - fire = iss_valid_o & (|(iss_unit_o & unit_ready_i) | iss_illegal_o).
  - Illegal instructions ignore unit_ready_i and fire once state_allows.
- Fields: iss_* are driven from the buffer and stay stable while iss_valid_o=1 and ~fire.
- Scoreboard update per cycle:
  - pending_next = (pending & ~clr) | set, with set = onehot(rd) when fire & rd_v & rd!=0.
  - Set wins over clear on the same index.
- FSM (buf_s = buffered dec_serial_i | dec_illegal_i):
  - RUN: state_allows = ~buf_s. If buf_v & buf_s, go to DRAIN.
  - DRAIN: state_allows = (pending==0 after clr). On fire, go to SERIAL.
  - SERIAL: no issue, dec_ready_o=0. On serial_done_i, go to RUN; the next instruction may issue the following cycle.
  - serial_done_i outside SERIAL is ignored.
- stall_cnt_o: increments when buf_v & ~fire & ~flush_i; saturates at 32'hFFFF_FFFF; not cleared by flush_i.
- flush_i (highest priority after reset):
  - Next cycle: buffer empty, pending=0, state=RUN.
  - In the flush cycle: iss_valid_o=0, no set, no accept.
- wb_rd_i=0 has no effect. A writeback to a non-pending register has no effect.

Test Plan:
- RAW stall: issue add x5 (alu ready), then add x6,x5,x1; hold wb off for 3 cycles -> iss_valid_o=0 for 3 cycles, stall_cnt_o=3. Assert wb_valid_i[0]=1 with wb_rd=5 -> second instruction fires in that same cycle, and pending[6]=1 the next cycle.
- x0 destination: 4 back-to-back alu writes to x0 with dec_valid_i held -> one fire per cycle, pending stays 0, stall_cnt_o=0.
- Serialise: pending x3 set, buffer csrrw (serial) -> DRAIN; wb x3 -> csrrw fires that cycle -> SERIAL, dec_ready_o=0. Pulse serial_done_i -> RUN; next add fires the cycle after.
- Backpressure: div instruction with unit_ready_i[5]=0 for 5 cycles -> iss_valid_o=1 and fields stable for 5 cycles, stall_cnt_o+=5; fires on the first ready cycle.
- Flush in DRAIN with pending {x3,x7}: assert flush_i -> next cycle state=RUN, pending=0, buffer empty, dec_ready_o=1, stall_cnt_o unchanged.
- Async reset mid-SERIAL: drop reset_n between clock edges -> all outputs 0 immediately; after release, state=RUN, dec_ready_o=1.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decoder-to-scoreboard and scoreboard-to-execution-unit signal bundle.
// The slave modport is the issue scoreboard; the master is the decoder/execution side.
interface issue_scoreboard_if #(
  parameter int NBR_UNIT      = 6,
  parameter int NBR_OPERATION = 6,
  parameter int XLEN          = 32
);
  logic                     dec_valid_i;
  logic                     dec_ready_o;
  logic                     dec_rs1_v_i;
  logic                     dec_rs2_v_i;
  logic                     dec_rd_v_i;
  logic [4:0]               dec_rs1_i;
  logic [4:0]               dec_rs2_i;
  logic [4:0]               dec_rd_i;
  logic [NBR_UNIT-1:0]      dec_unit_i;
  logic [NBR_OPERATION-1:0] dec_op_i;
  logic [XLEN-1:0]          dec_imm_i;
  logic [XLEN-1:0]          dec_pc_i;
  logic                     dec_serial_i;
  logic                     dec_illegal_i;

  logic                     iss_valid_o;
  logic [NBR_UNIT-1:0]      iss_unit_o;
  logic [NBR_OPERATION-1:0] iss_op_o;
  logic [XLEN-1:0]          iss_imm_o;
  logic [XLEN-1:0]          iss_pc_o;
  logic [4:0]               iss_rs1_o;
  logic [4:0]               iss_rs2_o;
  logic [4:0]               iss_rd_o;
  logic                     iss_rd_v_o;
  logic                     iss_illegal_o;
  logic [NBR_UNIT-1:0]      unit_ready_i;

  modport master (
    output dec_valid_i, dec_rs1_v_i, dec_rs2_v_i, dec_rd_v_i, dec_rs1_i, dec_rs2_i,
           dec_rd_i, dec_unit_i, dec_op_i, dec_imm_i, dec_pc_i, dec_serial_i,
           dec_illegal_i, unit_ready_i,
    input  dec_ready_o, iss_valid_o, iss_unit_o, iss_op_o, iss_imm_o, iss_pc_o,
           iss_rs1_o, iss_rs2_o, iss_rd_o, iss_rd_v_o, iss_illegal_o
  );

  modport slave (
    input  dec_valid_i, dec_rs1_v_i, dec_rs2_v_i, dec_rd_v_i, dec_rs1_i, dec_rs2_i,
           dec_rd_i, dec_unit_i, dec_op_i, dec_imm_i, dec_pc_i, dec_serial_i,
           dec_illegal_i, unit_ready_i,
    output dec_ready_o, iss_valid_o, iss_unit_o, iss_op_o, iss_imm_o, iss_pc_o,
           iss_rs1_o, iss_rs2_o, iss_rd_o, iss_rd_v_o, iss_illegal_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Single-entry issue buffer with a 32-register pending scoreboard and a
// drain/serial sequencer for instructions that must execute alone.
//
// state     | meaning
// ST_RUN    | normal issue; a buffered serialising instruction moves us to ST_DRAIN
// ST_DRAIN  | serialising instruction waits until no register is pending, then issues
// ST_SERIAL | serialising instruction in flight; decoder held off until serial_done_i
module issue_scoreboard #(
  parameter int NBR_UNIT      = 6,
  parameter int NBR_OPERATION = 6,
  parameter int NBR_WB        = 2,
  parameter int XLEN          = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush_i,
  issue_scoreboard_if.slave   bus,
  input  logic [NBR_WB-1:0]   wb_valid_i,
  input  logic [5*NBR_WB-1:0] wb_rd_i,
  input  logic                serial_done_i,
  output logic [31:0]         stall_cnt_o
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SERIAL} state_t;

  state_t                   state;
  logic                     buf_v;
  logic                     buf_rs1_v;
  logic                     buf_rs2_v;
  logic                     buf_rd_v;
  logic                     buf_serial;
  logic                     buf_illegal;
  logic [4:0]               buf_rs1;
  logic [4:0]               buf_rs2;
  logic [4:0]               buf_rd;
  logic [NBR_UNIT-1:0]      buf_unit;
  logic [NBR_OPERATION-1:0] buf_op;
  logic [XLEN-1:0]          buf_imm;
  logic [XLEN-1:0]          buf_pc;
  logic [31:0]              pending;
  logic [31:0]              clr;
  logic [31:0]              eff;
  logic [31:0]              set_v;
  logic [31:0]              stall_cnt;
  logic                     buf_s;
  logic                     hz;
  logic                     allows;
  logic                     iss_valid;
  logic                     fire;
  logic                     dec_ready;
  logic                     accept;

  always_comb begin
    clr = '0;
    for (int p = 0; p < NBR_WB; p++) begin
      if (wb_valid_i[p]) clr[wb_rd_i[p*5 +: 5]] = 1'b1;
    end
    clr[0] = 1'b0;
  end

  // Writebacks landing this cycle already count as resolved (bypass).
  assign eff   = pending & ~clr;
  assign buf_s = buf_serial | buf_illegal;
  assign hz    = (buf_rs1_v & eff[buf_rs1]) | (buf_rs2_v & eff[buf_rs2]) |
                 (buf_rd_v & eff[buf_rd]);

  always_comb begin
    allows = 1'b0;
    case (state)
      ST_RUN:   allows = ~buf_s;
      ST_DRAIN: allows = (eff == 32'd0);
      default:  allows = 1'b0;
    endcase
  end

  assign iss_valid = buf_v & ~hz & allows & ~flush_i;
  assign fire      = iss_valid & ((|(buf_unit & bus.unit_ready_i)) | buf_illegal);
  assign dec_ready = reset_n & ~flush_i & (state != ST_SERIAL) & (~buf_v | fire);
  assign accept    = bus.dec_valid_i & dec_ready;

  always_comb begin
    set_v = '0;
    if (fire & buf_rd_v & (buf_rd != 5'd0)) set_v[buf_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      buf_v       <= 1'b0;
      buf_rs1_v   <= 1'b0;
      buf_rs2_v   <= 1'b0;
      buf_rd_v    <= 1'b0;
      buf_serial  <= 1'b0;
      buf_illegal <= 1'b0;
      buf_rs1     <= '0;
      buf_rs2     <= '0;
      buf_rd      <= '0;
      buf_unit    <= '0;
      buf_op      <= '0;
      buf_imm     <= '0;
      buf_pc      <= '0;
      pending     <= '0;
      stall_cnt   <= '0;
    end else if (flush_i) begin
      state   <= ST_RUN;
      buf_v   <= 1'b0;
      pending <= '0;
    end else begin
      buf_v <= accept | (buf_v & ~fire);
      if (accept) begin
        buf_rs1_v   <= bus.dec_rs1_v_i;
        buf_rs2_v   <= bus.dec_rs2_v_i;
        buf_rd_v    <= bus.dec_rd_v_i;
        buf_serial  <= bus.dec_serial_i;
        buf_illegal <= bus.dec_illegal_i;
        buf_rs1     <= bus.dec_rs1_i;
        buf_rs2     <= bus.dec_rs2_i;
        buf_rd      <= bus.dec_rd_i;
        buf_unit    <= bus.dec_unit_i;
        buf_op      <= bus.dec_op_i;
        buf_imm     <= bus.dec_imm_i;
        buf_pc      <= bus.dec_pc_i;
      end
      // Set is ORed after the clear so a same-index set wins.
      pending <= ((pending & ~clr) | set_v) & 32'hFFFF_FFFE;
      if (buf_v & ~fire & (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      case (state)
        ST_RUN:    if (buf_v & buf_s) state <= ST_DRAIN;
        ST_DRAIN:  if (fire) state <= ST_SERIAL;
        ST_SERIAL: if (serial_done_i) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign bus.dec_ready_o   = dec_ready;
  assign bus.iss_valid_o   = iss_valid;
  assign bus.iss_unit_o    = buf_unit;
  assign bus.iss_op_o      = buf_op;
  assign bus.iss_imm_o     = buf_imm;
  assign bus.iss_pc_o      = buf_pc;
  assign bus.iss_rs1_o     = buf_rs1;
  assign bus.iss_rs2_o     = buf_rs2;
  assign bus.iss_rd_o      = buf_rd;
  assign bus.iss_rd_v_o    = buf_rd_v;
  assign bus.iss_illegal_o = buf_illegal;
  assign stall_cnt_o       = stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: per-cycle vector table for hazard/x0
// traffic, then hand sequences for backpressure, serialisation, flush and reset.
module tb_issue_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        flush_i;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_rd_i;
  logic        serial_done_i;
  logic [31:0] stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  issue_scoreboard_if #(.NBR_UNIT(6), .NBR_OPERATION(6), .XLEN(32)) bus ();

  issue_scoreboard #(.NBR_UNIT(6), .NBR_OPERATION(6), .NBR_WB(2), .XLEN(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (flush_i),
    .bus          (bus),
    .wb_valid_i   (wb_valid_i),
    .wb_rd_i      (wb_rd_i),
    .serial_done_i(serial_done_i),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  rdy;
    logic [1:0]  wbv;
    logic [4:0]  wbr;
    logic        e_ready;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [5:0] rdy,
                              input logic [1:0] wbv, input logic [4:0] wbr,
                              input logic e_ready, input logic e_valid,
                              input logic [4:0] e_rd, input logic [31:0] e_stall);
    vec_t v;
    v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rdy = rdy;
    v.wbv = wbv; v.wbr = wbr; v.e_ready = e_ready; v.e_valid = e_valid;
    v.e_rd = e_rd; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.dec_valid_i   = 1'b0;
    bus.dec_rs1_v_i   = 1'b0;
    bus.dec_rs2_v_i   = 1'b0;
    bus.dec_rd_v_i    = 1'b0;
    bus.dec_rs1_i     = '0;
    bus.dec_rs2_i     = '0;
    bus.dec_rd_i      = '0;
    bus.dec_unit_i    = '0;
    bus.dec_op_i      = '0;
    bus.dec_imm_i     = '0;
    bus.dec_pc_i      = '0;
    bus.dec_serial_i  = 1'b0;
    bus.dec_illegal_i = 1'b0;
    flush_i           = 1'b0;
    wb_valid_i        = '0;
    wb_rd_i           = '0;
    serial_done_i     = 1'b0;
  endtask

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rd_v, input logic [5:0] unit, input logic ser,
                     input logic ill, input logic [31:0] pc);
    bus.dec_valid_i   = 1'b1;
    bus.dec_rs1_v_i   = 1'b1;
    bus.dec_rs2_v_i   = 1'b1;
    bus.dec_rd_v_i    = rd_v;
    bus.dec_rs1_i     = rs1;
    bus.dec_rs2_i     = rs2;
    bus.dec_rd_i      = rd;
    bus.dec_unit_i    = unit;
    bus.dec_op_i      = 6'h2A;
    bus.dec_imm_i     = pc ^ 32'h5A5A_0000;
    bus.dec_pc_i      = pc;
    bus.dec_serial_i  = ser;
    bus.dec_illegal_i = ill;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid_i = 2'b01;
    wb_rd_i    = {5'd0, r};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string nm, input logic e_ready, input logic e_valid);
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, bus.dec_ready_o}, {31'd0, e_ready});
    chk({nm, "_valid"}, {31'd0, bus.iss_valid_o}, {31'd0, e_valid});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(1, 1, 2, 5, 6'h3F, 2'b00, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 5, 1, 6, 6'h3F, 2'b00, 0, 1, 1, 5, 0);
    vecs[2]  = mk(0, 0, 0, 0, 6'h3F, 2'b00, 0, 0, 0, 6, 0);
    vecs[3]  = mk(0, 0, 0, 0, 6'h3F, 2'b00, 0, 0, 0, 6, 1);
    vecs[4]  = mk(0, 0, 0, 0, 6'h3F, 2'b00, 0, 0, 0, 6, 2);
    vecs[5]  = mk(0, 0, 0, 0, 6'h3F, 2'b01, 5, 1, 1, 6, 3);
    vecs[6]  = mk(1, 6, 0, 7, 6'h3F, 2'b00, 0, 1, 0, 6, 3);
    vecs[7]  = mk(0, 0, 0, 0, 6'h3F, 2'b00, 0, 0, 0, 7, 3);
    vecs[8]  = mk(0, 0, 0, 0, 6'h3F, 2'b10, 6, 1, 1, 7, 4);
    vecs[9]  = mk(0, 0, 0, 0, 6'h3F, 2'b01, 7, 1, 0, 7, 4);
    vecs[10] = mk(1, 0, 0, 0, 6'h3F, 2'b00, 0, 1, 0, 7, 4);
    vecs[11] = mk(1, 0, 0, 0, 6'h3F, 2'b00, 0, 1, 1, 0, 4);
    vecs[12] = mk(1, 0, 0, 0, 6'h3F, 2'b00, 0, 1, 1, 0, 4);
    vecs[13] = mk(1, 0, 0, 0, 6'h3F, 2'b00, 0, 1, 1, 0, 4);
    vecs[14] = mk(0, 0, 0, 0, 6'h3F, 2'b00, 0, 1, 1, 0, 4);
    vecs[15] = mk(0, 0, 0, 0, 6'h3F, 2'b00, 0, 1, 0, 0, 4);

    idle();
    bus.unit_ready_i = 6'h3F;
    reset_n = 1'b0;
    #3;
    chk("in_reset_ready", {31'd0, bus.dec_ready_o}, 32'd0);
    chk("in_reset_valid", {31'd0, bus.iss_valid_o}, 32'd0);
    #9 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.dec_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, bus.iss_valid_o}, 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);
    chk("rst_unit", {26'd0, bus.iss_unit_o}, 32'd0);
    chk("rst_pc", bus.iss_pc_o, 32'd0);
    tick();

    // RAW stall with writeback bypass, then x0 destinations back to back
    for (int i = 0; i < 16; i++) begin
      idle();
      bus.unit_ready_i = vecs[i].rdy;
      if (vecs[i].dv) ins(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 1'b1, 6'b000001, 1'b0, 1'b0, i);
      wb_valid_i = vecs[i].wbv;
      wb_rd_i    = {vecs[i].wbr, vecs[i].wbr};
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), {31'd0, bus.dec_ready_o}, {31'd0, vecs[i].e_ready});
      chk($sformatf("row%0d_valid", i), {31'd0, bus.iss_valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("row%0d_rd", i), {27'd0, bus.iss_rd_o}, {27'd0, vecs[i].e_rd});
      chk($sformatf("row%0d_stall", i), stall_cnt_o, vecs[i].e_stall);
      tick();
    end

    // Divider backpressure: held request with stable fields
    idle();
    bus.unit_ready_i = 6'b011111;
    ins(5'd1, 5'd2, 5'd8, 1'b1, 6'b100000, 1'b0, 1'b0, 32'h100);
    cyc_chk("bp_acc", 1'b1, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), {31'd0, bus.iss_valid_o}, 32'd1);
      chk($sformatf("bp%0d_unit", k), {26'd0, bus.iss_unit_o}, 32'h20);
      chk($sformatf("bp%0d_pc", k), bus.iss_pc_o, 32'h100);
      chk($sformatf("bp%0d_stall", k), stall_cnt_o, 32'd4 + k);
      tick();
    end
    bus.unit_ready_i = 6'h3F;
    cyc_chk("bp_fire", 1'b1, 1'b1);
    chk("bp_fire_stall", stall_cnt_o, 32'd9);
    tick();
    wb(5'd8);
    cyc_chk("bp_after", 1'b1, 1'b0);
    chk("bp_after_stall", stall_cnt_o, 32'd9);
    tick();

    // Serialise: drain pending x3, csr issues alone, early serial_done ignored
    idle();
    ins(5'd1, 5'd2, 5'd3, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h200);
    tick();
    ins(5'd0, 5'd0, 5'd0, 1'b0, 6'b000001, 1'b1, 1'b0, 32'h204);
    cyc_chk("ser_prev", 1'b1, 1'b1);
    tick();
    idle();
    cyc_chk("ser_run", 1'b0, 1'b0);
    tick();
    serial_done_i = 1'b1;
    cyc_chk("ser_drain", 1'b0, 1'b0);
    tick();
    idle();
    wb(5'd3);
    ins(5'd1, 5'd2, 5'd10, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h208);
    cyc_chk("ser_fire", 1'b1, 1'b1);
    tick();
    idle();
    ins(5'd1, 5'd2, 5'd12, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h20C);
    cyc_chk("ser_hold", 1'b0, 1'b0);
    tick();
    serial_done_i = 1'b1;
    cyc_chk("ser_done", 1'b0, 1'b0);
    tick();
    idle();
    cyc_chk("ser_next", 1'b1, 1'b1);
    chk("ser_next_rd", {27'd0, bus.iss_rd_o}, 32'd10);
    chk("ser_next_stall", stall_cnt_o, 32'd13);
    tick();
    wb(5'd10);
    cyc_chk("ser_clear", 1'b1, 1'b0);
    tick();

    // Flush while draining with x3 and x7 pending
    idle();
    ins(5'd1, 5'd2, 5'd3, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h300);
    tick();
    ins(5'd1, 5'd2, 5'd7, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h304);
    tick();
    ins(5'd0, 5'd0, 5'd0, 1'b0, 6'b000001, 1'b1, 1'b0, 32'h308);
    tick();
    idle();
    cyc_chk("fl_run", 1'b0, 1'b0);
    tick();
    flush_i = 1'b1;
    cyc_chk("fl_cycle", 1'b0, 1'b0);
    chk("fl_cycle_stall", stall_cnt_o, 32'd14);
    tick();
    idle();
    ins(5'd3, 5'd7, 5'd11, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h30C);
    cyc_chk("fl_after", 1'b1, 1'b0);
    chk("fl_after_stall", stall_cnt_o, 32'd14);
    tick();
    idle();
    cyc_chk("fl_nohaz", 1'b1, 1'b1);
    tick();
    wb(5'd11);
    tick();

    // Illegal fires with no unit ready, then async reset while in SERIAL
    idle();
    bus.unit_ready_i = 6'b000000;
    ins(5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, 1'b0, 1'b1, 32'h400);
    cyc_chk("ill_acc", 1'b1, 1'b0);
    tick();
    idle();
    cyc_chk("ill_run", 1'b0, 1'b0);
    tick();
    cyc_chk("ill_fire", 1'b1, 1'b1);
    chk("ill_flag", {31'd0, bus.iss_illegal_o}, 32'd1);
    tick();
    cyc_chk("ill_serial", 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, bus.dec_ready_o}, 32'd0);
    chk("arst_valid", {31'd0, bus.iss_valid_o}, 32'd0);
    chk("arst_illegal", {31'd0, bus.iss_illegal_o}, 32'd0);
    chk("arst_pc", bus.iss_pc_o, 32'd0);
    chk("arst_stall", stall_cnt_o, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    bus.unit_ready_i = 6'h3F;
    cyc_chk("arst_rel", 1'b1, 1'b0);
    tick();
    ins(5'd1, 5'd2, 5'd4, 1'b1, 6'b000001, 1'b0, 1'b0, 32'h500);
    tick();
    idle();
    cyc_chk("arst_run", 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
